remote_cmd_sender: RTL and testbench

//  Remote-side command initiator for the quadcopter command link. Accepts a

---
 rtl/remote_cmd_sender.sv | 107 ++++++++++
 tb/tb_remote_cmd_sender.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/remote_cmd_sender.sv
// Remote-side command initiator: sends {cmd, data_hi, data_lo} over a byte UART,
// then waits for a single response byte with a timeout.
module remote_cmd_sender #(
  parameter int FAST_SIM     = 1,
  parameter int RESP_TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        timeout,
  output logic        busy
);

  localparam int LIMIT = (FAST_SIM != 0) ? 512 : RESP_TIMEOUT;
  localparam int TW    = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(LIMIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TX_CMD    = 3'd1;
  localparam logic [2:0] TX_HI     = 3'd2;
  localparam logic [2:0] TX_LO     = 3'd3;
  localparam logic [2:0] WAIT_RESP = 3'd4;

  logic [2:0]    state;
  logic [15:0]   data_q;
  logic [TW-1:0] timer;
  logic          rx_new;

  // rx_rdy stays high for the cycle in which clr_rx_rdy is asserted, so a
  // byte already being knocked down must not be consumed a second time.
  assign rx_new = rx_rdy && !clr_rx_rdy;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_q     <= '0;
      timer      <= '0;
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
      clr_rx_rdy <= 1'b0;
      cmd_sent   <= 1'b0;
      resp       <= 8'h00;
      resp_rdy   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      trmt       <= 1'b0;
      cmd_sent   <= 1'b0;
      clr_rx_rdy <= 1'b0;
      // Bytes arriving outside WAIT_RESP are stale: drop them without capture.
      if (rx_new && state != WAIT_RESP)
        clr_rx_rdy <= 1'b1;
      case (state)
        IDLE: if (snd_cmd) begin
          data_q   <= data;
          tx_data  <= cmd;
          trmt     <= 1'b1;
          resp_rdy <= 1'b0;
          timeout  <= 1'b0;
          state    <= TX_CMD;
        end
        TX_CMD: if (tx_done) begin
          tx_data <= data_q[15:8];
          trmt    <= 1'b1;
          state   <= TX_HI;
        end
        TX_HI: if (tx_done) begin
          tx_data <= data_q[7:0];
          trmt    <= 1'b1;
          state   <= TX_LO;
        end
        TX_LO: if (tx_done) begin
          cmd_sent <= 1'b1;
          timer    <= '0;
          state    <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (timer != TMR_LAST)
            timer <= timer + 1'b1;
          // Response has priority over a simultaneous expiry.
          if (rx_new) begin
            resp       <= rx_data;
            resp_rdy   <= 1'b1;
            clr_rx_rdy <= 1'b1;
            state      <= IDLE;
          end else if (timer == TMR_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_cmd_sender.sv
// Directed bench for remote_cmd_sender: byte sequencing, response capture,
// timeout, stale rx bytes, busy-time snd_cmd and mid-transfer reset.
module tb_remote_cmd_sender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        tx_done = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        trmt, clr_rx_rdy, cmd_sent, resp_rdy, timeout, busy;
  logic [7:0]  tx_data, resp;

  int n_vec = 0;
  int n_err = 0;

  remote_cmd_sender #(.FAST_SIM(1), .RESP_TIMEOUT(1048576)) dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
    .tx_done(tx_done), .rx_rdy(rx_rdy), .rx_data(rx_data), .trmt(trmt),
    .tx_data(tx_data), .clr_rx_rdy(clr_rx_rdy), .cmd_sent(cmd_sent),
    .resp(resp), .resp_rdy(resp_rdy), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse snd_cmd for one clock; ends on the negedge where the first trmt shows.
  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    snd_cmd = 1'b1; cmd = c; data = d;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  // Expects trmt now (or within a bound), checks the byte and its hold,
  // optionally fires a snd_cmd while busy, then pulses tx_done.
  task automatic tx_byte(input string nm, input logic [7:0] exp, input bit inject);
    int n = 0;
    while (trmt !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (trmt !== 1'b1 || tx_data !== exp) begin
      n_err++;
      $display("FAIL %s start: trmt=%b tx_data=%h, want trmt=1 tx_data=%h", nm, trmt, tx_data, exp);
    end
    if (inject) begin
      snd_cmd = 1'b1; cmd = 8'h05; data = 16'hBEEF;
    end
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (trmt !== 1'b0 || tx_data !== exp || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s hold: trmt=%b tx_data=%h busy=%b, want 0/%h/1", nm, trmt, tx_data, busy, exp);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic check_sent(input string nm);
    n_vec++;
    if (cmd_sent !== 1'b1 || trmt !== 1'b0) begin
      n_err++;
      $display("FAIL %s cmd_sent: cmd_sent=%b trmt=%b, want 1/0", nm, cmd_sent, trmt);
    end
  endtask

  task automatic give_resp(input string nm, input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b;
    @(negedge clk);
    n_vec++;
    if (resp !== b || resp_rdy !== 1'b1 || clr_rx_rdy !== 1'b1 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL %s resp: resp=%h rdy=%b clr=%b to=%b, want %h/1/1/0", nm, resp, resp_rdy, clr_rx_rdy, timeout, b);
    end
    rx_rdy = 1'b0;
    @(negedge clk);
    n_vec++;
    if (clr_rx_rdy !== 1'b0 || busy !== 1'b0 || resp_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL %s after: clr=%b busy=%b rdy=%b, want 0/0/1", nm, clr_rx_rdy, busy, resp_rdy);
    end
  endtask

  task automatic check_zero(input string nm);
    n_vec++;
    if ({trmt, tx_data, clr_rx_rdy, cmd_sent, resp, resp_rdy, timeout, busy} !== '0) begin
      n_err++;
      $display("FAIL %s: trmt=%b tx=%h clr=%b sent=%b resp=%h rdy=%b to=%b busy=%b, want all 0",
               nm, trmt, tx_data, clr_rx_rdy, cmd_sent, resp, resp_rdy, timeout, busy);
    end
  endtask

  task automatic test_reset();
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");
  endtask

  task automatic test_send();
    send_cmd(8'h02, 16'h1234);
    tx_byte("t1_cmd", 8'h02, 1'b0);
    tx_byte("t1_hi", 8'h12, 1'b0);
    tx_byte("t1_lo", 8'h34, 1'b0);
    check_sent("t1");
    @(negedge clk);
    n_vec++;
    if (cmd_sent !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL t1 sent_pulse: cmd_sent=%b busy=%b, want 0/1", cmd_sent, busy);
    end
  endtask

  task automatic test_resp();
    give_resp("t2", 8'hA5);
  endtask

  task automatic test_timeout();
    send_cmd(8'h06, 16'h0001);
    n_vec++;
    if (resp_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL t3 rdy_clear: resp_rdy=%b, want 0", resp_rdy);
    end
    tx_byte("t3_cmd", 8'h06, 1'b0);
    tx_byte("t3_hi", 8'h00, 1'b0);
    tx_byte("t3_lo", 8'h01, 1'b0);
    check_sent("t3");
    repeat (511) @(negedge clk);
    n_vec++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL t3 early: timeout=%b busy=%b, want 0/1", timeout, busy);
    end
    @(negedge clk);
    n_vec++;
    if (timeout !== 1'b1 || busy !== 1'b0 || resp !== 8'hA5 || resp_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL t3 expiry: timeout=%b busy=%b resp=%h rdy=%b, want 1/0/a5/0", timeout, busy, resp, resp_rdy);
    end
  endtask

  task automatic test_busy_ignore();
    send_cmd(8'h03, 16'hC3D4);
    n_vec++;
    if (timeout !== 1'b0) begin
      n_err++;
      $display("FAIL t4 to_clear: timeout=%b, want 0", timeout);
    end
    tx_byte("t4_cmd", 8'h03, 1'b0);
    tx_byte("t4_hi", 8'hC3, 1'b1);
    tx_byte("t4_lo", 8'hD4, 1'b0);
    check_sent("t4");
    give_resp("t4", 8'h11);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (trmt !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL t4 extra_tx: trmt=%b busy=%b, want 0/0", trmt, busy);
      end
    end
  endtask

  task automatic test_stale();
    rx_rdy = 1'b1; rx_data = 8'h5A;
    @(negedge clk);
    n_vec++;
    if (clr_rx_rdy !== 1'b1 || resp !== 8'h11 || resp_rdy !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t5 stale: clr=%b resp=%h rdy=%b busy=%b, want 1/11/1/0", clr_rx_rdy, resp, resp_rdy, busy);
    end
    rx_rdy = 1'b0;
    @(negedge clk);
    n_vec++;
    if (clr_rx_rdy !== 1'b0 || resp !== 8'h11) begin
      n_err++;
      $display("FAIL t5 after: clr=%b resp=%h, want 0/11", clr_rx_rdy, resp);
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(8'h04, 16'h7788);
    tx_byte("t6_cmd", 8'h04, 1'b0);
    rst_n = 1'b0;
    #1 check_zero("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (trmt !== 1'b0) begin
        n_err++;
        $display("FAIL t6 stray_trmt: trmt=%b, want 0", trmt);
      end
    end
    n_vec++;
    send_cmd(8'h08, 16'h9ABC);
    tx_byte("t6_cmd2", 8'h08, 1'b0);
    tx_byte("t6_hi2", 8'h9A, 1'b0);
    tx_byte("t6_lo2", 8'hBC, 1'b0);
    check_sent("t6");
    give_resp("t6", 8'hA5);
  endtask

  task automatic test_race();
    send_cmd(8'h07, 16'h0102);
    tx_byte("t7_cmd", 8'h07, 1'b0);
    tx_byte("t7_hi", 8'h01, 1'b0);
    tx_byte("t7_lo", 8'h02, 1'b0);
    check_sent("t7");
    repeat (511) @(negedge clk);
    give_resp("t7", 8'h3C);
  endtask

  initial begin
    test_reset();
    test_send();
    test_resp();
    test_timeout();
    test_busy_ignore();
    test_stale();
    test_reset_mid();
    test_race();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
